// File: rtl/weight_acc_drain.sv
// weight_acc_drain: drains N signed words from the weight accumulator's
// dequeue interface and presents them as one packed row over valid/ready.
// A strobe issued in cycle k is answered by the accumulator in cycle k+1.
// The answer is captured only when it pairs with a strobe, which filters out
// the accumulator's sticky valid.
module weight_acc_drain #(
    parameter int WEIGHT_ACC_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_in,
    input  logic [7:0]                    count_in,
    output logic                          dequeue_out,
    input  logic                          acc_valid_in,
    input  logic signed [15:0]            acc_data_in,
    output logic                          row_valid_out,
    input  logic                          row_ready_in,
    output logic [16*WEIGHT_ACC_WIDTH-1:0] row_data_out,
    output logic [7:0]                    row_count_out,
    output logic                          busy_out,
    output logic                          err_out
);

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {IDLE, REQ, CAPT, OUT} state_t;

    state_t state, state_nxt;

    logic [7:0] n_reg, n_nxt;
    logic [7:0] req_cnt, req_nxt;
    logic [7:0] cap_cnt, cap_nxt;
    logic       dq_d1;
    logic       dequeue_nxt, err_nxt, row_valid_nxt, busy_nxt;
    logic [7:0] row_count_nxt;
    logic signed [DATA_W-1:0] slots     [WEIGHT_ACC_WIDTH];
    logic signed [DATA_W-1:0] slots_nxt [WEIGHT_ACC_WIDTH];

    logic count_ok;
    logic draining;
    logic capture;
    logic missing;
    logic cap_last;

    assign count_ok = (count_in != 8'd0) && (count_in <= 8'(WEIGHT_ACC_WIDTH));
    assign draining = (state == REQ) || (state == CAPT);
    // A response is only meaningful in the cycle right after a strobe.
    assign capture  = draining && dq_d1 && acc_valid_in;
    assign missing  = draining && dq_d1 && !acc_valid_in;
    assign cap_last = (cap_cnt + 8'd1) == n_reg;

    // State, counters, slots and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            n_reg         <= 8'd0;
            req_cnt       <= 8'd0;
            cap_cnt       <= 8'd0;
            dq_d1         <= 1'b0;
            dequeue_out   <= 1'b0;
            err_out       <= 1'b0;
            row_valid_out <= 1'b0;
            row_count_out <= 8'd0;
            busy_out      <= 1'b0;
            for (int i = 0; i < WEIGHT_ACC_WIDTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            state         <= state_nxt;
            n_reg         <= n_nxt;
            req_cnt       <= req_nxt;
            cap_cnt       <= cap_nxt;
            dq_d1         <= dequeue_out;
            dequeue_out   <= dequeue_nxt;
            err_out       <= err_nxt;
            row_valid_out <= row_valid_nxt;
            row_count_out <= row_count_nxt;
            busy_out      <= busy_nxt;
            for (int i = 0; i < WEIGHT_ACC_WIDTH; i++) begin
                slots[i] <= slots_nxt[i];
            end
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_in && count_ok) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (missing) begin
                    state_nxt = IDLE;
                end else if (req_cnt == n_reg) begin
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                if (missing) begin
                    state_nxt = IDLE;
                end else if (capture && cap_last) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (row_ready_in) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the strobe, counters, slots and row outputs.
    always_comb begin
        n_nxt         = n_reg;
        req_nxt       = req_cnt;
        cap_nxt       = cap_cnt;
        dequeue_nxt   = 1'b0;
        err_nxt       = 1'b0;
        row_valid_nxt = row_valid_out;
        row_count_nxt = row_count_out;
        for (int i = 0; i < WEIGHT_ACC_WIDTH; i++) begin
            slots_nxt[i] = slots[i];
        end

        case (state)
            IDLE: begin
                if (start_in) begin
                    if (count_ok) begin
                        n_nxt       = count_in;
                        // req_cnt counts strobes already issued, so the first
                        // strobe raised here counts as one.
                        req_nxt     = 8'd1;
                        cap_nxt     = 8'd0;
                        dequeue_nxt = 1'b1;
                        for (int i = 0; i < WEIGHT_ACC_WIDTH; i++) begin
                            slots_nxt[i] = '0;
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            REQ, CAPT: begin
                if (missing) begin
                    err_nxt = 1'b1;
                    for (int i = 0; i < WEIGHT_ACC_WIDTH; i++) begin
                        slots_nxt[i] = '0;
                    end
                end else begin
                    if (state == REQ && req_cnt != n_reg) begin
                        dequeue_nxt = 1'b1;
                        req_nxt     = req_cnt + 8'd1;
                    end
                    if (capture) begin
                        for (int i = 0; i < WEIGHT_ACC_WIDTH; i++) begin
                            if (cap_cnt == 8'(i)) begin
                                slots_nxt[i] = acc_data_in;
                            end
                        end
                        cap_nxt = cap_cnt + 8'd1;
                        if (cap_last) begin
                            row_valid_nxt = 1'b1;
                            row_count_nxt = n_reg;
                        end
                    end
                end
            end
            OUT: begin
                if (row_ready_in) begin
                    row_valid_nxt = 1'b0;
                    row_count_nxt = 8'd0;
                    for (int i = 0; i < WEIGHT_ACC_WIDTH; i++) begin
                        slots_nxt[i] = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy_nxt = (state_nxt != IDLE);

    // Pack the slot registers into the row bus, slot 0 in the low bits.
    always_comb begin
        row_data_out = '0;
        for (int i = 0; i < WEIGHT_ACC_WIDTH; i++) begin
            row_data_out[DATA_W*i +: DATA_W] = slots[i];
        end
    end

endmodule

// File: tb/tb_weight_acc_drain.sv
// Bench for weight_acc_drain: table-driven drains, hand-written reset
// sequences, and randomized drains against a row-level reference model.
module tb_weight_acc_drain;

    localparam int W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_in;
    logic [7:0]        count_in;
    logic              dequeue_out;
    logic              acc_valid_in;
    logic [15:0]       acc_data_in;
    logic              row_valid_out;
    logic              row_ready_in;
    logic [16*W-1:0]   row_data_out;
    logic [7:0]        row_count_out;
    logic              busy_out;
    logic              err_out;

    int vectors = 0;
    int miscompares = 0;

    // Accumulator model state: answers each strobe one cycle later.
    logic [15:0] acc_q[$];
    logic        last_dq = 1'b0;
    int          resp_idx = 0;
    int          drop_idx = -1;
    int          sticky_cfg = 0;
    int          sticky_left = 0;

    typedef struct {
        int          count;
        logic [63:0] words;
        int          ready_delay;
        int          drop;
        int          sticky;
        logic        exp_err;
        logic [7:0]  exp_cnt;
        logic [63:0] exp_row;
    } vec_t;

    vec_t tbl[7];

    weight_acc_drain #(.WEIGHT_ACC_WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_in      (start_in),
        .count_in      (count_in),
        .dequeue_out   (dequeue_out),
        .acc_valid_in  (acc_valid_in),
        .acc_data_in   (acc_data_in),
        .row_valid_out (row_valid_out),
        .row_ready_in  (row_ready_in),
        .row_data_out  (row_data_out),
        .row_count_out (row_count_out),
        .busy_out      (busy_out),
        .err_out       (err_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance one clock, then update the accumulator's response for this cycle.
    task automatic tick();
        logic resp;
        @(posedge clk);
        #1;
        resp    = last_dq;
        last_dq = dequeue_out;
        if (resp) begin
            if (resp_idx == drop_idx) begin
                acc_valid_in = 1'b0;
            end else begin
                acc_valid_in = 1'b1;
                acc_data_in  = (acc_q.size() > 0) ? acc_q.pop_front() : 16'hDEAD;
            end
            resp_idx++;
            sticky_left = sticky_cfg;
        end else if (sticky_left > 0) begin
            acc_valid_in = 1'b1;
            acc_data_in  = 16'($urandom);
            sticky_left--;
        end else begin
            acc_valid_in = 1'b0;
            acc_data_in  = 16'($urandom);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_dq"},    64'(dequeue_out),   64'd0);
        check({tag, "_vld"},   64'(row_valid_out), 64'd0);
        check({tag, "_busy"},  64'(busy_out),      64'd0);
        check({tag, "_err"},   64'(err_out),       64'd0);
        check({tag, "_data"},  row_data_out,       64'd0);
        check({tag, "_count"}, 64'(row_count_out), 64'd0);
    endtask

    // One complete drain from start pulse until the bench is back in IDLE.
    task automatic drain(input vec_t v);
        int  n;
        int  r;
        int  last;
        logic exp_dq, exp_err, exp_vld, exp_busy;
        acc_q.delete();
        for (int i = 0; i < W; i++) acc_q.push_back(v.words[16*i +: 16]);
        resp_idx   = 0;
        drop_idx   = v.drop;
        sticky_cfg = v.sticky;
        start_in   = 1'b1;
        count_in   = v.count[7:0];
        tick();
        start_in = 1'b0;
        count_in = 8'($urandom);
        if (v.exp_err) begin
            check("bad_count_err",  64'(err_out),     64'd1);
            check("bad_count_dq",   64'(dequeue_out), 64'd0);
            check("bad_count_busy", 64'(busy_out),    64'd0);
            tick();
            check("bad_count_err_end", 64'(err_out),     64'd0);
            check("bad_count_dq_end",  64'(dequeue_out), 64'd0);
            check("bad_count_idle",    64'(busy_out),    64'd0);
            return;
        end
        n    = v.count;
        r    = v.ready_delay;
        last = (v.drop >= 0) ? v.drop + 4 : n + 3 + r;
        for (int c = 1; c <= last; c++) begin
            exp_dq   = (c <= n) && (v.drop < 0 || c <= v.drop + 2);
            exp_err  = (v.drop >= 0) && (c == v.drop + 3);
            exp_vld  = (v.drop < 0) && (c >= n + 2) && (c <= n + 2 + r);
            exp_busy = (v.drop >= 0) ? (c <= v.drop + 2) : (c <= n + 2 + r);
            check("dequeue", 64'(dequeue_out),   64'(exp_dq));
            check("err",     64'(err_out),       64'(exp_err));
            check("row_vld", 64'(row_valid_out), 64'(exp_vld));
            check("busy",    64'(busy_out),      64'(exp_busy));
            if (exp_vld) begin
                check("row_data",  row_data_out,       v.exp_row);
                check("row_count", 64'(row_count_out), 64'(v.exp_cnt));
            end
            if (c == last && v.drop < 0) begin
                check("row_data_clr",  row_data_out,       64'd0);
                check("row_count_clr", 64'(row_count_out), 64'd0);
            end
            if (c < n + 2) row_ready_in = 1'($urandom);
            else           row_ready_in = (v.drop < 0) && (c == n + 2 + r);
            if (c == last) row_ready_in = 1'b0;
            if (c < last) tick();
        end
        row_ready_in = 1'b0;
    endtask

    initial begin
        vec_t v;
        rst          = 1'b1;
        start_in     = 1'b0;
        count_in     = 8'd0;
        row_ready_in = 1'b0;
        acc_valid_in = 1'b0;
        acc_data_in  = 16'd0;

        tbl[0] = '{4, 64'h7FFF_FFFE_0002_0001, 0,  -1, 0, 1'b0, 8'd4, 64'h7FFF_FFFE_0002_0001};
        tbl[1] = '{2, 64'h5555_AAAA_8000_1234, 10, -1, 0, 1'b0, 8'd2, 64'h0000_0000_8000_1234};
        tbl[2] = '{0, 64'h1111_2222_3333_4444, 0,  -1, 0, 1'b1, 8'd0, 64'h0};
        tbl[3] = '{5, 64'h1111_2222_3333_4444, 0,  -1, 0, 1'b1, 8'd0, 64'h0};
        tbl[4] = '{4, 64'h4444_3333_2222_1111, 0,   2, 0, 1'b0, 8'd0, 64'h0};
        tbl[5] = '{1, 64'h0000_0000_0000_00C3, 1,  -1, 3, 1'b0, 8'd1, 64'h0000_0000_0000_00C3};
        tbl[6] = '{3, 64'hFFFF_8001_0000_7FFE, 2,  -1, 1, 1'b0, 8'd3, 64'h0000_8001_0000_7FFE};

        // Reset, then five idle cycles with nothing happening.
        tick();
        tick();
        check_quiet("reset");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_quiet("idle");
        end

        for (int t = 0; t < 7; t++) drain(tbl[t]);

        // Reset during REQ after two strobes aborts the drain.
        acc_q.delete();
        for (int i = 0; i < W; i++) acc_q.push_back(16'(16'h0A00 + i));
        resp_idx = 0; drop_idx = -1; sticky_cfg = 0;
        start_in = 1'b1;
        count_in = 8'd4;
        tick();
        start_in = 1'b0;
        check("abort_dq1", 64'(dequeue_out), 64'd1);
        tick();
        check("abort_dq2", 64'(dequeue_out), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_quiet("abort_rst");
        for (int i = 0; i < 4; i++) begin
            tick();
            check_quiet("abort_after");
        end

        // Randomized drains against the row-level model.
        for (int k = 0; k < 40; k++) begin
            v.count       = $urandom_range(0, 6);
            v.words       = {$urandom, $urandom};
            v.ready_delay = $urandom_range(0, 4);
            v.sticky      = $urandom_range(0, 3);
            v.exp_err     = (v.count == 0) || (v.count > W);
            v.drop        = (!v.exp_err && $urandom_range(0, 4) == 0) ? $urandom_range(0, v.count - 1) : -1;
            v.exp_cnt     = v.count[7:0];
            v.exp_row     = 64'd0;
            if (!v.exp_err) begin
                for (int i = 0; i < v.count; i++) v.exp_row[16*i +: 16] = v.words[16*i +: 16];
            end
            drain(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
